// File: rtl/johnson_seq_if.sv
// Control and status bundle for the Johnson/ring sequencer.
// The master drives the controls and the slave (the sequencer) drives the status.
interface johnson_seq_if #(
    parameter int N = 8
);
    localparam int PW = $clog2(2 * N);

    logic          en;
    logic          dir;
    logic          mode;
    logic          ld;
    logic [N-1:0]  d;
    logic [N-1:0]  Q;
    logic [PW-1:0] phase;
    logic          wrap;
    logic          bad;

    modport master (
        output en, dir, mode, ld, d,
        input  Q, phase, wrap, bad
    );

    modport slave (
        input  en, dir, mode, ld, d,
        output Q, phase, wrap, bad
    );
endinterface

// File: rtl/johnson_seq.sv
// Parametrised Johnson/ring sequencer with load, illegal-state self-correction,
// decoded phase index and a registered wrap pulse.
module johnson_seq #(
    parameter int N = 8
) (
    input  logic         C,
    input  logic         R,
    johnson_seq_if.slave bus
);
    localparam int PW = $clog2(2 * N);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_LOAD,
        OP_FIX,
        OP_STEP
    } op_e;

    logic [N-1:0]  cnt_q, cnt_d;
    logic          wrap_q, wrap_d;
    logic [N-1:0]  inv;
    logic          legal_j, legal_r, bad;
    logic [PW-1:0] pop, ph_j, ph_r, phase, last;
    op_e           op;

    // Decode: legality, popcount and phase are all pure functions of Q and mode.
    always_comb begin
        inv     = ~cnt_q;
        // Low run of ones (incl. zero) or high run of ones (complement is a low run).
        legal_j = ((cnt_q & (cnt_q + ONE)) == '0) || ((inv & (inv + ONE)) == '0);
        legal_r = (cnt_q != '0) && ((cnt_q & (cnt_q - ONE)) == '0);
        bad     = bus.mode ? !legal_r : !legal_j;
        pop     = '0;
        ph_r    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pop = pop + PW'(cnt_q[i]);
            if (cnt_q[i]) ph_r = PW'(i);
        end
        // 2N - p is taken modulo 2^PW, which is exact because 2N - p < 2N <= 2^PW.
        ph_j  = ((cnt_q == '0) || cnt_q[0]) ? pop : PW'(2 * N) - pop;
        phase = bad ? '0 : (bus.mode ? ph_r : ph_j);
        last  = bus.mode ? PW'(N - 1) : PW'(2 * N - 1);
    end

    always_comb begin
        op     = OP_HOLD;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.ld)      op = OP_LOAD;
        else if (bus.en) op = bad ? OP_FIX : OP_STEP;

        case (op)
            OP_LOAD: cnt_d = bus.d;
            OP_FIX:  cnt_d = bus.mode ? ONE : '0;
            OP_STEP: begin
                if (!bus.dir) cnt_d = {cnt_q[N-2:0], bus.mode ? cnt_q[N-1] : ~cnt_q[N-1]};
                else          cnt_d = {bus.mode ? cnt_q[0] : ~cnt_q[0], cnt_q[N-1:1]};
                wrap_d = bus.dir ? (phase == '0) : (phase == last);
            end
            default: ;
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.Q     = cnt_q;
    assign bus.wrap  = wrap_q;
    assign bus.phase = phase;
    assign bus.bad   = bad;
endmodule

// File: doc/johnson_seq.md
# johnson_seq

Parametrised Johnson/ring sequencer: the next generation of the 8-bit Johnson counter on the lab board. It adds configurable width, run-time direction and mode select, synchronous load, illegal-state detection with self-correction, a decoded phase index and a wrap pulse. It sits between a pushbutton-derived clock (or `hz100`) and the LED/seven-segment display logic in `top`.

## Interface
- `N`, default 8: register width, N ≥ 2.
- `PW`, default `$clog2(2*N)` (derived localparam, not overridable): phase index width.

- `C`  in  1: clock; all state changes on its rising edge.
- `R`  in  1: asynchronous, active-high reset.
- `en`  in  1: step enable.
- `dir`  in  1: 0 = shift left (phase increments), 1 = shift right (phase decrements).
- `mode`  in  1: 0 = Johnson (twisted ring, 2N states), 1 = ring (one-hot, N states).
- `ld`  in  1: synchronous load of `d`.
- `d`  in  N: load value.
- `Q`  out  N: counter register.
- `phase`  out  PW: decoded position in the sequence.
- `wrap`  out  1: one-cycle pulse when the sequence rolls over.
- `bad`  out  1: `Q` is not a legal state for the current `mode`.

## Operation
- Priority: `R` > `ld` > `en`. With `ld` and `en` both low, `Q` holds.
- `ld`=1: `Q` <= `d` verbatim. Legality is not checked, `wrap` is not asserted, and `dir`/`mode` are ignored.
- `en`=1, `ld`=0, `bad`=1: `Q` <= the seed for the current mode (Johnson: all zeros; ring: `1` in bit 0). No shift occurs. `wrap` stays 0.
- `en`=1, `ld`=0, `bad`=0: step as follows.
  - Johnson left: `{Q[N-2:0], ~Q[N-1]}`.
  - Johnson right: `{~Q[0], Q[N-1:1]}`.
  - Ring left: `{Q[N-2:0], Q[N-1]}`.
  - Ring right: `{Q[0], Q[N-1:1]}`.
- Johnson legal states: all zeros; a run of k ones at the LSB end (1 ≤ k ≤ N); a run of ones at the MSB end with zeros below.
- Ring legal states: exactly one bit set. All-zeros is illegal in ring mode.
- `phase`, Johnson mode, with p = popcount(Q):
  - If `Q`==0 or `Q[0]`==1: phase = p.
  - Otherwise: phase = 2N − p.
  - Resulting ranges: 0…2N−1. Left step gives +1 mod 2N; right step gives −1 mod 2N.
- `phase`, ring mode: index of the set bit, 0…N−1. Left gives +1 mod N; right gives −1 mod N.
- `phase` = 0 whenever `bad`=1.
- `wrap`: set on an enabled legal step whose phase transition is one of:
  - left: last → 0 (2N−1→0 Johnson, N−1→0 ring);
  - right: 0 → last.
  - Cleared on every other edge.
- Changing `mode` mid-sequence takes effect immediately. `bad` and `phase` are re-evaluated against the new mode, and the next enabled edge either steps or corrects accordingly.
- Changing `dir` takes effect on the next enabled edge. There is no wrap unless the resulting transition crosses the boundary.

## Timing
- Reset values: `Q`=0, `wrap`=0. With `mode`=0: `phase`=0, `bad`=0. With `mode`=1: `phase`=0, `bad`=1.
- `R` clears the registers asynchronously in the same cycle it rises and holds them while high. The first edge after `R` falls acts normally. Asserting `R` mid-sequence discards state.
- `Q` and `wrap` are registered. `wrap` is high for exactly the one cycle in which `Q` shows the post-wrap value.
- `phase` and `bad` are combinational decodes of the current `Q` and `mode`, with zero latency relative to `Q`.
- Step latency is 1 clock from the sampled `en`. Correction also takes 1 clock and returns to a legal state in 1 edge, never more.
- Continuous `en`: Johnson period is 2N clocks, ring period is N clocks, with one `wrap` per period.

## Test plan
- N=8, `mode`=0, `dir`=0, `en`=1 for 17 clocks from reset -> `Q`: 00→01→03→…→FF→FE→…→80→00; `phase` 0…15→0; `wrap`=1 only with the 16th `Q` update (Q=00); `bad`=0 throughout.
- N=8, Johnson, `dir`=1 from reset, 2 clocks -> `Q`=80 (`phase`=15, `wrap`=1), then C0 (`phase`=14, `wrap`=0).
- N=8, `mode`=1 from reset -> `bad`=1 before the first edge; 1st enabled edge gives `Q`=01, `bad`=0, `wrap`=0; 8 further left steps give 02…80→01 with `wrap`=1 on the return to 01.
- `ld`=1, `d`=8'h5A, `mode`=0 -> `Q`=5A, `bad`=1, `phase`=0; next `en` edge gives `Q`=00. `ld`=1 and `en`=1 with `d`=8'h0F -> `Q`=0F (load wins), `phase`=4.
- Johnson at `Q`=07 (`phase`=3), switch to `mode`=1 -> `bad`=1 immediately; next `en` edge gives `Q`=01.
- At `Q`=3F mid-run, pulse `R` between edges -> `Q`=00 and `wrap`=0 asynchronously before the next edge; `R` held across 3 edges with `en`=1 leaves `Q`=00.
